// File: rtl/mem_pkg.sv
// Shared types for the memory stage: access-size encoding, FSM states and lane helpers.
// Optional feature macro used by this slice: MEM_MISALIGN_TRAP_EN.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // A 32-bit datapath has no dword lane, so a dword request degrades to a word.
    function automatic mem_size_e effective_size(input logic [1:0] size, input int unsigned xlen);
        if (xlen == 32 && size == SZ_DWORD) begin
            return SZ_WORD;
        end
        return mem_size_e'(size);
    endfunction

    function automatic logic [7:0] size_be_mask(input mem_size_e size);
        logic [7:0] mask;
        case (size)
            SZ_BYTE: mask = 8'h01;
            SZ_HALF: mask = 8'h03;
            SZ_WORD: mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] off, input mem_size_e size);
        logic [2:0] low_bits;
        case (size)
            SZ_BYTE: low_bits = 3'b000;
            SZ_HALF: low_bits = 3'b001;
            SZ_WORD: low_bits = 3'b011;
            default: low_bits = 3'b111;
        endcase
        return |(off & low_bits);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: aligned address, byte enables, store shift
// and load extract/extend, all derived from the low address bits.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [1:0]        size,
    input  logic              rdu,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   aligned_addr,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [XLEN-1:0]   load_data
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [OFF_W-1:0] off;
    mem_size_e        size_eff;
    logic [15:0]      be_wide;
    logic [XLEN-1:0]  rdata_sh;

    assign off          = addr[OFF_W-1:0];
    assign size_eff     = effective_size(size, XLEN);
    assign aligned_addr = {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    // Shifting into a wider vector and truncating drops lanes past the bus edge.
    assign be_wide    = {8'h00, size_be_mask(size_eff)} << off;
    assign be         = be_wide[NB-1:0];
    assign wdata_lane = wdata << {off, 3'b000};
    assign rdata_sh   = rdata >> {off, 3'b000};

    always_comb begin
        load_data = rdata_sh;
        case (size_eff)
            SZ_BYTE: begin
                if (rdu) load_data = XLEN'(rdata_sh[7:0]);
                else     load_data = XLEN'($signed(rdata_sh[7:0]));
            end
            SZ_HALF: begin
                if (rdu) load_data = XLEN'(rdata_sh[15:0]);
                else     load_data = XLEN'($signed(rdata_sh[15:0]));
            end
            SZ_WORD: begin
                if (rdu) load_data = XLEN'(rdata_sh[31:0]);
                else     load_data = XLEN'($signed(rdata_sh[31:0]));
            end
            default: load_data = rdata_sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU ops pass straight to writeback, loads/stores hold in BUSY
// until the data memory answers. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_writeback,
    input  logic              ex_mem_w,
    input  logic              ex_mem_r,
    input  logic              ex_mem_rdu,
    input  logic [1:0]        ex_size,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic              dmem_drdy,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_writeback,
    output logic              wb_trap,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_W-1:0]  wb_rd
);

    mem_state_e       state_q, state_d;
    logic             dmem_req_q, dmem_req_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             we_q, we_d;
    logic             rdu_q, rdu_d;
    logic             writeback_q, writeback_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_writeback_q, wb_writeback_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  load_data;
    logic             is_mem;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam int OFF_W = $clog2(XLEN / 8);
    logic wb_trap_q, wb_trap_d;
    logic misaligned_ex;

    assign misaligned_ex = is_misaligned(3'(ex_alu_result[OFF_W-1:0]),
                                         effective_size(ex_size, XLEN));
`endif

    // The memory side only ever sees captured fields, so it cannot wiggle while BUSY.
    mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .addr         (addr_q),
        .size         (size_q),
        .rdu          (rdu_q),
        .wdata        (wdata_q),
        .rdata        (dmem_rdata),
        .aligned_addr (dmem_addr),
        .be           (dmem_be),
        .wdata_lane   (dmem_wdata),
        .load_data    (load_data)
    );

    assign is_mem = ex_mem_w | ex_mem_r;

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        size_d         = size_q;
        we_d           = we_q;
        rdu_d          = rdu_q;
        writeback_d    = writeback_q;
        rd_d           = rd_q;
        wb_valid_d     = 1'b0;
        wb_writeback_d = wb_writeback_q;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
        wb_trap_d      = wb_trap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_result;
                        wb_writeback_d = ex_writeback;
                        wb_rd_d        = ex_rd;
`ifdef MEM_MISALIGN_TRAP_EN
                        wb_trap_d      = 1'b0;
`endif
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (misaligned_ex) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_result;
                        wb_writeback_d = 1'b0;
                        wb_rd_d        = ex_rd;
                        wb_trap_d      = 1'b1;
                    end
`endif
                    else begin
                        // A set store bit wins over a set load bit.
                        addr_d      = ex_alu_result;
                        wdata_d     = ex_wdata;
                        size_d      = ex_size;
                        we_d        = ex_mem_w;
                        rdu_d       = ex_mem_rdu;
                        writeback_d = ex_writeback;
                        rd_d        = ex_rd;
                        dmem_req_d  = 1'b1;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_drdy) begin
                    wb_valid_d     = 1'b1;
                    wb_data_d      = we_q ? addr_q : load_data;
                    wb_writeback_d = writeback_q & ~we_q;
                    wb_rd_d        = rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
                    wb_trap_d      = 1'b0;
`endif
                    dmem_req_d     = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                dmem_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            dmem_req_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            size_q         <= '0;
            we_q           <= 1'b0;
            rdu_q          <= 1'b0;
            writeback_q    <= 1'b0;
            rd_q           <= '0;
            wb_valid_q     <= 1'b0;
            wb_writeback_q <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_trap_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            size_q         <= size_d;
            we_q           <= we_d;
            rdu_q          <= rdu_d;
            writeback_q    <= writeback_d;
            rd_q           <= rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_writeback_q <= wb_writeback_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_trap_q      <= wb_trap_d;
`endif
        end
    end

    assign ex_ready     = (state_q == ST_IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = we_q;
    assign wb_valid     = wb_valid_q;
    assign wb_writeback = wb_writeback_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign wb_trap      = wb_trap_q;
`else
    assign wb_trap      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (XLEN=32): ALU pass-through, loads/stores with lane
// steering, stall handling, reset abandon, and the MEM_MISALIGN_TRAP_EN path when defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_writeback;
    logic        ex_mem_w;
    logic        ex_mem_r;
    logic        ex_mem_rdu;
    logic [1:0]  ex_size;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_wdata;
    logic [5:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_drdy;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_writeback;
    logic        wb_trap;
    logic [31:0] wb_data;
    logic [5:0]  wb_rd;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage #(
        .XLEN  (32),
        .REG_W (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_writeback  (ex_writeback),
        .ex_mem_w      (ex_mem_w),
        .ex_mem_r      (ex_mem_r),
        .ex_mem_rdu    (ex_mem_rdu),
        .ex_size       (ex_size),
        .ex_alu_result (ex_alu_result),
        .ex_wdata      (ex_wdata),
        .ex_rd         (ex_rd),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_drdy     (dmem_drdy),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_writeback  (wb_writeback),
        .wb_trap       (wb_trap),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wbk, input logic mw, input logic mr,
                                 input logic rdu, input logic [1:0] sz, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [5:0] rd);
        ex_valid      = v;
        ex_writeback  = wbk;
        ex_mem_w      = mw;
        ex_mem_r      = mr;
        ex_mem_rdu    = rdu;
        ex_size       = sz;
        ex_alu_result = addr;
        ex_wdata      = wdata;
        ex_rd         = rd;
    endtask

    task automatic runAlu(input string tag, input logic [31:0] res, input logic [5:0] rd, input logic wbk);
        @(negedge clk);
        applyStimulus(1'b1, wbk, 1'b0, 1'b0, 1'b0, 2'b10, res, 32'h0, rd);
        checkOutput({tag, "/ready_pre"}, 64'(ex_ready), 64'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput({tag, "/wb_valid"}, 64'(wb_valid), 64'd1);
        checkOutput({tag, "/wb_data"}, 64'(wb_data), 64'(res));
        checkOutput({tag, "/wb_rd"}, 64'(wb_rd), 64'(rd));
        checkOutput({tag, "/wb_writeback"}, 64'(wb_writeback), 64'(wbk));
        checkOutput({tag, "/wb_trap"}, 64'(wb_trap), 64'd0);
        checkOutput({tag, "/ready_post"}, 64'(ex_ready), 64'd1);
        @(negedge clk);
        checkOutput({tag, "/wb_valid_pulse"}, 64'(wb_valid), 64'd0);
    endtask

    task automatic runMem(input string tag, input logic wbk, input logic mw, input logic mr,
                          input logic rdu, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [5:0] rd, input int delay,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic exp_we, input logic chk_data, input logic [31:0] exp_data,
                          input logic exp_wbk);
        @(negedge clk);
        applyStimulus(1'b1, wbk, mw, mr, rdu, sz, addr, wdata, rd);
        checkOutput({tag, "/req_idle"}, 64'(dmem_req), 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
        checkOutput({tag, "/ready_busy"}, 64'(ex_ready), 64'd0);
        checkOutput({tag, "/req"}, 64'(dmem_req), 64'd1);
        checkOutput({tag, "/addr"}, 64'(dmem_addr), 64'(exp_addr));
        checkOutput({tag, "/be"}, 64'(dmem_be), 64'(exp_be));
        checkOutput({tag, "/wdata"}, 64'(dmem_wdata), 64'(exp_wdata));
        checkOutput({tag, "/we"}, 64'(dmem_we), 64'(exp_we));
        checkOutput({tag, "/wb_valid_busy"}, 64'(wb_valid), 64'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput({tag, "/stall_req"}, 64'(dmem_req), 64'd1);
            checkOutput({tag, "/stall_ready"}, 64'(ex_ready), 64'd0);
            checkOutput({tag, "/stall_be"}, 64'(dmem_be), 64'(exp_be));
            checkOutput({tag, "/stall_addr"}, 64'(dmem_addr), 64'(exp_addr));
            checkOutput({tag, "/stall_wb_valid"}, 64'(wb_valid), 64'd0);
        end
        dmem_drdy  = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_drdy  = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput({tag, "/wb_valid"}, 64'(wb_valid), 64'd1);
        if (chk_data) checkOutput({tag, "/wb_data"}, 64'(wb_data), 64'(exp_data));
        checkOutput({tag, "/wb_writeback"}, 64'(wb_writeback), 64'(exp_wbk));
        checkOutput({tag, "/wb_rd"}, 64'(wb_rd), 64'(rd));
        checkOutput({tag, "/wb_trap"}, 64'(wb_trap), 64'd0);
        checkOutput({tag, "/ready_done"}, 64'(ex_ready), 64'd1);
        checkOutput({tag, "/req_done"}, 64'(dmem_req), 64'd0);
        @(negedge clk);
        checkOutput({tag, "/wb_valid_pulse"}, 64'(wb_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        dmem_drdy  = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
        repeat (3) @(negedge clk);
        checkOutput("rst/ready", 64'(ex_ready), 64'd1);
        checkOutput("rst/req", 64'(dmem_req), 64'd0);
        checkOutput("rst/wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rst/wb_writeback", 64'(wb_writeback), 64'd0);
        checkOutput("rst/wb_trap", 64'(wb_trap), 64'd0);
        checkOutput("rst/wb_data", 64'(wb_data), 64'd0);
        checkOutput("rst/wb_rd", 64'(wb_rd), 64'd0);
        rst_n = 1'b1;

        runAlu("alu_1234", 32'h0000_1234, 6'd5, 1'b1);
        runAlu("alu_nowb", 32'hFFFF_0000, 6'd0, 1'b0);

        //      tag       wbk   mw    mr    rdu   sz     addr          wdata         rd     dly rdata         exp_addr      be       exp_wdata     we    chk   exp_data      exp_wbk
        runMem("lb_late", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0,        6'd7,  3,  32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'h0,        1'b0, 1'b1, 32'hFFFF_FF80, 1'b1);
        runMem("lhu",     1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_1002, 32'h0,        6'd8,  0,  32'h8001_AAAA, 32'h0000_1000, 4'b1100, 32'h0,        1'b0, 1'b1, 32'h0000_8001, 1'b1);
        runMem("sb",      1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_1001, 32'h0000_005A, 6'd9,  1,  32'h0,        32'h0000_1000, 4'b0010, 32'h0000_5A00, 1'b1, 1'b0, 32'h0,        1'b0);
        runMem("lh",      1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_2000, 32'h0,        6'd10, 0,  32'h1234_F00F, 32'h0000_2000, 4'b0011, 32'h0,        1'b0, 1'b1, 32'hFFFF_F00F, 1'b1);
        runMem("ld_as_w", 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_2004, 32'h0,        6'd11, 2,  32'hCAFE_F00D, 32'h0000_2004, 4'b1111, 32'h0,        1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        runMem("rw_store",1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_3008, 32'h0102_0304, 6'd12, 0,  32'h5555_5555, 32'h0000_3008, 4'b1111, 32'h0102_0304, 1'b1, 1'b0, 32'h0,        1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_1002, 32'h0, 6'd13);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
        checkOutput("trap/wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("trap/wb_trap", 64'(wb_trap), 64'd1);
        checkOutput("trap/wb_writeback", 64'(wb_writeback), 64'd0);
        checkOutput("trap/req", 64'(dmem_req), 64'd0);
        checkOutput("trap/ready", 64'(ex_ready), 64'd1);
        @(negedge clk);
        checkOutput("trap/wb_valid_pulse", 64'(wb_valid), 64'd0);
        checkOutput("trap/req_after", 64'(dmem_req), 64'd0);
        runAlu("alu_after_trap", 32'h0000_00AB, 6'd14, 1'b1);
`else
        runMem("lw_misal",1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_1002, 32'h0,        6'd13, 0,  32'h1122_3344, 32'h0000_1000, 4'b1100, 32'h0,        1'b0, 1'b1, 32'h0000_1122, 1'b1);
        runMem("sw_misal",1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1003, 32'hAABB_CCDD, 6'd14, 0,  32'h0,        32'h0000_1000, 4'b1000, 32'hDD00_0000, 1'b1, 1'b0, 32'h0,        1'b0);
`endif

        // Reset while a load is outstanding, then a stray completion strobe.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0, 6'd15);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
        checkOutput("rstbusy/req_before", 64'(dmem_req), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rstbusy/req", 64'(dmem_req), 64'd0);
        checkOutput("rstbusy/ready", 64'(ex_ready), 64'd1);
        checkOutput("rstbusy/wb_valid", 64'(wb_valid), 64'd0);
        dmem_drdy  = 1'b1;
        dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_drdy  = 1'b0;
        checkOutput("rstbusy/late_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rstbusy/late_req", 64'(dmem_req), 64'd0);
        checkOutput("rstbusy/late_ready", 64'(ex_ready), 64'd1);
        checkOutput("rstbusy/late_wb_data", 64'(wb_data), 64'd0);
        @(negedge clk);
        checkOutput("rstbusy/idle_wb_valid", 64'(wb_valid), 64'd0);

        runAlu("alu_final", 32'h0BAD_F00D, 6'd63, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
